// File: rtl/rectangle128_dec_keygen.sv
// rectangle128_dec_keygen: RECTANGLE-128 decryption round-key generator.
// Runs the key schedule forward to K(ROUNDS), then streams keys back down to K0.
module rectangle128_dec_keygen #(
   parameter int ROUNDS = 25,
   parameter logic [4:0] RC_INIT = 5'h01
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_start,
   input  logic [127:0] iv_key,
   output logic         o_busy,
   output logic [63:0]  ov_rkey,
   output logic [4:0]   ov_rkey_idx,
   output logic         o_rkey_valid,
   input  logic         i_rkey_ready,
   output logic         o_rkey_last,
   output logic         o_done
);
   typedef enum logic [1:0] {IDLE, FWD, OUT} state_t;
   localparam logic [63:0] SBOX = 64'h24F8D30B97E1AC56;
   localparam logic [63:0] SINV = 64'hD5B2837C601EAF49;
   localparam logic [4:0]  LAST = 5'(ROUNDS - 1);
   state_t state;
   logic [127:0] key;
   logic [4:0] rc, cnt, rc_prev;

   function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
      return (x << n) | (x >> (32 - n));
   endfunction

   // Only columns 0..7 pass through the S-box; the upper 24 columns are untouched.
   function automatic logic [127:0] sub_cols(input logic [127:0] s, input logic [63:0] tbl);
      logic [127:0] r;
      logic [3:0] v;
      r = s;
      for (int j = 0; j < 8; j++) begin
         v = tbl[4 * int'({s[96+j], s[64+j], s[32+j], s[j]}) +: 4];
         r[j] = v[0];
         r[32+j] = v[1];
         r[64+j] = v[2];
         r[96+j] = v[3];
      end
      return r;
   endfunction

   function automatic logic [127:0] f_upd(input logic [127:0] s, input logic [4:0] c);
      logic [127:0] t;
      logic [31:0] n0;
      t = sub_cols(s, SBOX);
      n0 = rotl(t[31:0], 8) ^ t[63:32];
      n0[4:0] = n0[4:0] ^ c;
      return {t[31:0], rotl(t[95:64], 16) ^ t[127:96], t[95:64], n0};
   endfunction

   function automatic logic [127:0] g_upd(input logic [127:0] s, input logic [4:0] c);
      logic [31:0] r0;
      r0 = s[31:0] ^ {27'd0, c};
      return sub_cols({s[95:64] ^ rotl(s[63:32], 16), s[63:32],
                       r0 ^ rotl(s[127:96], 8), s[127:96]}, SINV);
   endfunction

   assign rc_prev = {rc[0] ^ rc[3], rc[4:1]};
   assign ov_rkey = {key[111:96], key[79:64], key[47:32], key[15:0]};
   assign ov_rkey_idx = cnt;
   assign o_rkey_last = o_rkey_valid && cnt == 5'd0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         key <= '0;
         rc <= '0;
         cnt <= '0;
         o_busy <= 1'b0;
         o_rkey_valid <= 1'b0;
         o_done <= 1'b0;
      end else begin
         o_done <= 1'b0;
         case (state)
            IDLE: if (i_start) begin
               key <= iv_key;
               rc <= RC_INIT;
               cnt <= '0;
               o_busy <= 1'b1;
               state <= FWD;
            end
            FWD: begin
               key <= f_upd(key, rc);
               rc <= {rc[3:0], rc[4] ^ rc[2]};
               cnt <= cnt + 5'd1;
               if (cnt == LAST) begin
                  o_rkey_valid <= 1'b1;
                  state <= OUT;
               end
            end
            OUT: if (i_rkey_ready) begin
               if (cnt != 5'd0) begin
                  key <= g_upd(key, rc_prev);
                  rc <= rc_prev;
                  cnt <= cnt - 5'd1;
               end else begin
                  o_rkey_valid <= 1'b0;
                  o_busy <= 1'b0;
                  o_done <= 1'b1;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
